// File: rtl/spi_pkg.sv
// Shared SPI definitions: data width, irq/status bit positions and register offsets.
package spi_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned STS_W  = 3;

    // irq_en_i bit positions
    localparam int unsigned BIT_THR = 0;
    localparam int unsigned BIT_EOT = 1;
    localparam int unsigned BIT_OVF = 2;
    // sts_o / sts_clr_i bit positions (EOT and OVF shared with the enables)
    localparam int unsigned BIT_UDF = 0;

    localparam logic [7:0] SPI_CTRL_OFS   = 8'h00;
    localparam logic [7:0] SPI_STATUS_OFS = 8'h04;
    localparam logic [7:0] SPI_TXDATA_OFS = 8'h08;
    localparam logic [7:0] SPI_RXDATA_OFS = 8'h0C;
    localparam logic [7:0] SPI_IRQEN_OFS  = 8'h10;
    localparam logic [7:0] SPI_THRESH_OFS = 8'h14;

endpackage

// File: rtl/spi_rx_buffer_if.sv
// Receive-buffer bus: producer push, APB pop path, status and interrupt controls.
interface spi_rx_buffer_if #(
    parameter int unsigned DEPTH_W = 2
);
    logic [spi_pkg::DATA_W-1:0] rx_data_i;
    logic                       rx_vld_i;
    logic                       eot_i;
    logic                       rd_req_i;
    logic [spi_pkg::DATA_W-1:0] rd_data_o;
    logic [DEPTH_W:0]           level_o;
    logic                       empty_o;
    logic                       full_o;
    logic [DEPTH_W:0]           thresh_i;
    logic [spi_pkg::STS_W-1:0]  irq_en_i;
    logic [spi_pkg::STS_W-1:0]  sts_clr_i;
    logic [spi_pkg::STS_W-1:0]  sts_o;
    logic                       irq_o;

    modport slave (
        input  rx_data_i, rx_vld_i, eot_i, rd_req_i, thresh_i, irq_en_i, sts_clr_i,
        output rd_data_o, level_o, empty_o, full_o, sts_o, irq_o
    );

    modport master (
        output rx_data_i, rx_vld_i, eot_i, rd_req_i, thresh_i, irq_en_i, sts_clr_i,
        input  rd_data_o, level_o, empty_o, full_o, sts_o, irq_o
    );
endinterface

// File: rtl/spi_rx_irq.sv
// Sticky status flags (udf, eot_pend, ovf) and the registered interrupt line.
module spi_rx_irq
    import spi_pkg::*;
#(
    parameter int unsigned LVL_W = 3
) (
    input  logic             pclk_i,
    input  logic             prstn_i,
    input  logic             eot_i,
    input  logic             ovf_set_i,
    input  logic             udf_set_i,
    input  logic [STS_W-1:0] sts_clr_i,
    input  logic [STS_W-1:0] irq_en_i,
    input  logic [LVL_W-1:0] level_i,
    input  logic [LVL_W-1:0] thresh_i,
    output logic [STS_W-1:0] sts_o,
    output logic             irq_o
);

    logic ovf_q, ovf_d;
    logic eot_q, eot_d;
    logic udf_q, udf_d;
    logic irq_q, irq_d;
    logic thr_c;

    // Set beats a same-cycle clear so an event is never lost.
    always_comb begin
        ovf_d = ovf_set_i | (ovf_q & ~sts_clr_i[BIT_OVF]);
        eot_d = eot_i     | (eot_q & ~sts_clr_i[BIT_EOT]);
        udf_d = udf_set_i | (udf_q & ~sts_clr_i[BIT_UDF]);
        thr_c = (thresh_i != '0) && (level_i >= thresh_i);
        irq_d = (thr_c & irq_en_i[BIT_THR])
              | (eot_q & irq_en_i[BIT_EOT])
              | (ovf_q & irq_en_i[BIT_OVF]);
    end

    always_ff @(posedge pclk_i or negedge prstn_i) begin
        if (!prstn_i) begin
            ovf_q <= 1'b0;
            eot_q <= 1'b0;
            udf_q <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            eot_q <= eot_d;
            udf_q <= udf_d;
            irq_q <= irq_d;
        end
    end

    assign sts_o = {ovf_q, eot_q, udf_q};
    assign irq_o = irq_q;

endmodule

// File: rtl/spi_rx_buffer.sv
// SPI receive FIFO: circular show-ahead RAM with level counter, sticky status and irq.
module spi_rx_buffer
    import spi_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned DEPTH_W = 2
) (
    input  logic             pclk_i,
    input  logic             prstn_i,
    spi_rx_buffer_if.slave   bus
);

    localparam int unsigned LVL_W = DEPTH_W + 1;

    logic [DATA_W-1:0]  mem_q [DEPTH];
    logic [DEPTH_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   level_q, level_d;

    logic empty_c, full_c;
    logic do_push_c, do_pop_c;
    logic ovf_set_c, udf_set_c;

    assign empty_c = (level_q == '0);
    assign full_c  = (level_q == LVL_W'(DEPTH));

    // A pop while full frees the slot the same-cycle push needs.
    always_comb begin
        do_pop_c  = bus.rd_req_i && !empty_c;
        do_push_c = bus.rx_vld_i && (!full_c || do_pop_c);
        ovf_set_c = bus.rx_vld_i && full_c && !bus.rd_req_i;
        udf_set_c = bus.rd_req_i && empty_c && !bus.rx_vld_i;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push_c) begin
            wr_ptr_d = wr_ptr_q + DEPTH_W'(1);
        end
        if (do_pop_c) begin
            rd_ptr_d = rd_ptr_q + DEPTH_W'(1);
        end
        level_d = level_q + LVL_W'(do_push_c) - LVL_W'(do_pop_c);
    end

    always_ff @(posedge pclk_i or negedge prstn_i) begin
        if (!prstn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage carries no reset; stale words are unreachable once pointers clear.
    always_ff @(posedge pclk_i) begin
        if (do_push_c) begin
            mem_q[wr_ptr_q] <= bus.rx_data_i;
        end
    end

    spi_rx_irq #(
        .LVL_W (LVL_W)
    ) u_irq (
        .pclk_i    (pclk_i),
        .prstn_i   (prstn_i),
        .eot_i     (bus.eot_i),
        .ovf_set_i (ovf_set_c),
        .udf_set_i (udf_set_c),
        .sts_clr_i (bus.sts_clr_i),
        .irq_en_i  (bus.irq_en_i),
        .level_i   (level_q),
        .thresh_i  (bus.thresh_i),
        .sts_o     (bus.sts_o),
        .irq_o     (bus.irq_o)
    );

    assign bus.rd_data_o = mem_q[rd_ptr_q];
    assign bus.level_o   = level_q;
    assign bus.empty_o   = empty_c;
    assign bus.full_o    = full_c;

endmodule

// File: tb/tb_spi_rx_buffer.sv
// Directed bench for spi_rx_buffer with a queue scoreboard of expected words.
module tb_spi_rx_buffer;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned DEPTH_W = 2;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    logic [31:0] sb [$];

    spi_rx_buffer_if #(.DEPTH_W(DEPTH_W)) bus ();

    spi_rx_buffer #(
        .DEPTH   (DEPTH),
        .DEPTH_W (DEPTH_W)
    ) dut (
        .pclk_i  (clk),
        .prstn_i (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus; head is checked before a legal pop, level after the edge.
    task automatic step(input logic vld, input logic [31:0] d, input logic rd,
                        input logic eot, input logic [2:0] clr);
        bit pop_ok;
        bit push_ok;
        @(negedge clk);
        pop_ok  = rd && (sb.size() > 0);
        push_ok = vld && ((sb.size() < DEPTH) || pop_ok);
        bus.rx_vld_i  = vld;
        bus.rx_data_i = d;
        bus.rd_req_i  = rd;
        bus.eot_i     = eot;
        bus.sts_clr_i = clr;
        if (pop_ok) check("head", bus.rd_data_o, sb[0]);
        @(posedge clk);
        #1;
        bus.rx_vld_i  = 1'b0;
        bus.rd_req_i  = 1'b0;
        bus.eot_i     = 1'b0;
        bus.sts_clr_i = 3'b000;
        if (pop_ok) void'(sb.pop_front());
        if (push_ok) sb.push_back(d);
        check("level", 32'(bus.level_o), 32'(sb.size()));
    endtask

    task automatic push(input logic [31:0] d);
        step(1'b1, d, 1'b0, 1'b0, 3'b000);
    endtask

    task automatic pop();
        step(1'b0, 32'h0, 1'b1, 1'b0, 3'b000);
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 1'b0, 1'b0, 3'b000);
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rst_n         = 1'b0;
        bus.rx_data_i = '0;
        bus.rx_vld_i  = 1'b0;
        bus.eot_i     = 1'b0;
        bus.rd_req_i  = 1'b0;
        bus.thresh_i  = '0;
        bus.irq_en_i  = 3'b000;
        bus.sts_clr_i = 3'b000;

        repeat (2) @(posedge clk);
        #1;
        check("rst_empty", 32'(bus.empty_o), 32'd1);
        check("rst_full",  32'(bus.full_o),  32'd0);
        check("rst_level", 32'(bus.level_o), 32'd0);
        check("rst_sts",   32'(bus.sts_o),   32'd0);
        check("rst_irq",   32'(bus.irq_o),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Fill to capacity
        push(32'h11111111);
        push(32'h22222222);
        push(32'h33333333);
        push(32'h44444444);
        check("fill_full",  32'(bus.full_o),  32'd1);
        check("fill_level", 32'(bus.level_o), 32'd4);

        // Overflow drops the word and raises ovf, irq follows a cycle later
        bus.irq_en_i = 3'b100;
        push(32'hDEADBEEF);
        check("ovf_sts",  32'(bus.sts_o[2]), 32'd1);
        check("ovf_head", bus.rd_data_o, 32'h11111111);
        check("ovf_irq_lag", 32'(bus.irq_o), 32'd0);
        idle();
        check("ovf_irq", 32'(bus.irq_o), 32'd1);
        step(1'b0, 32'h0, 1'b0, 1'b0, 3'b100);
        check("ovf_clr_sts", 32'(bus.sts_o[2]), 32'd0);
        idle();
        check("ovf_clr_irq", 32'(bus.irq_o), 32'd0);
        bus.irq_en_i = 3'b000;

        // Push with pop while full: both happen, no overflow
        step(1'b1, 32'h55555555, 1'b1, 1'b0, 3'b000);
        check("pp_full_level", 32'(bus.level_o), 32'd4);
        check("pp_full_ovf",   32'(bus.sts_o[2]), 32'd0);

        repeat (4) pop();
        check("drain_empty", 32'(bus.empty_o), 32'd1);

        // Push with pop while empty: push wins, no underflow
        step(1'b1, 32'h66666666, 1'b1, 1'b0, 3'b000);
        check("pp_empty_level", 32'(bus.level_o), 32'd1);
        check("pp_empty_udf",   32'(bus.sts_o[0]), 32'd0);
        pop();
        pop();
        check("udf_set", 32'(bus.sts_o[0]), 32'd1);
        check("udf_empty", 32'(bus.empty_o), 32'd1);
        step(1'b0, 32'h0, 1'b0, 1'b0, 3'b001);
        check("udf_clr", 32'(bus.sts_o[0]), 32'd0);

        // Threshold interrupt
        bus.thresh_i = 3'd3;
        bus.irq_en_i = 3'b001;
        push(32'hA0000001);
        push(32'hA0000002);
        check("thr_below", 32'(bus.irq_o), 32'd0);
        push(32'hA0000003);
        check("thr_lag", 32'(bus.irq_o), 32'd0);
        idle();
        check("thr_rise", 32'(bus.irq_o), 32'd1);
        pop();
        idle();
        check("thr_fall", 32'(bus.irq_o), 32'd0);
        bus.thresh_i = 3'd0;
        push(32'hA0000004);
        idle();
        idle();
        check("thr_disabled", 32'(bus.irq_o), 32'd0);
        repeat (3) pop();
        bus.irq_en_i = 3'b000;

        // EOT set beats same-cycle clear
        step(1'b0, 32'h0, 1'b0, 1'b1, 3'b010);
        check("eot_set_wins", 32'(bus.sts_o[1]), 32'd1);
        step(1'b0, 32'h0, 1'b0, 1'b0, 3'b010);
        check("eot_clr", 32'(bus.sts_o[1]), 32'd0);

        // Pointer wrap under continuous push/pop
        push(32'hB0000000);
        push(32'hB0000001);
        for (int i = 2; i < 12; i++) begin
            step(1'b1, 32'hB0000000 + 32'(i), 1'b1, 1'b0, 3'b000);
        end
        check("wrap_level", 32'(bus.level_o), 32'd2);

        // Asynchronous reset mid-operation
        rst_n = 1'b0;
        #1;
        check("mid_rst_level", 32'(bus.level_o), 32'd0);
        check("mid_rst_empty", 32'(bus.empty_o), 32'd1);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        push(32'hCAFEF00D);
        check("post_rst_head", bus.rd_data_o, 32'hCAFEF00D);
        pop();
        check("post_rst_empty", 32'(bus.empty_o), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_rx_buffer.md
SPI_RX_BUFFER -- requirements
Module: spi_rx_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of 32-bit entries (power of two, at least 2).
REQ-002 SHALL have parameter DEPTH_W, default 2, meaning log2(DEPTH).
REQ-003 SHALL have one clock, pclk_i (input, 1): all state is on its rising edge.
REQ-004 SHALL have reset prstn_i (input, 1): asynchronous, active-low.
REQ-005 SHALL have rx_data_i (input, 32): received SPI word.
REQ-006 SHALL have rx_vld_i (input, 1): push strobe; there is no backpressure to the producer.
REQ-007 SHALL have eot_i (input, 1): single-cycle end-of-transmission pulse.
REQ-008 SHALL have rd_req_i (input, 1): pop strobe from the APB read path.
REQ-009 SHALL have rd_data_o (output, 32): head entry (show-ahead).
REQ-010 SHALL have level_o (output, DEPTH_W+1): occupancy.
REQ-011 SHALL have empty_o and full_o (outputs, 1 each): decoded from level_o.
REQ-012 SHALL have thresh_i (input, DEPTH_W+1): interrupt threshold; 0 disables the threshold source.
REQ-013 SHALL have irq_en_i (input, 3): enables, with bit0 = threshold, bit1 = eot, bit2 = overflow.
REQ-014 SHALL have sts_clr_i (input, 3): write-1-to-clear strobes for sticky flags, with bit0 = underflow, bit1 = eot, bit2 = overflow.
REQ-015 SHALL have sts_o (output, 3): sticky flags {ovf, eot_pend, udf}.
REQ-016 SHALL have irq_o (output, 1): registered interrupt.

Function
REQ-017 SHALL store words in a circular RAM of DEPTH entries using DEPTH_W-bit write and read pointers that wrap from DEPTH-1 to 0, plus a (DEPTH_W+1)-bit level counter.
REQ-018 SHALL make rd_data_o equal the entry at the read pointer combinationally; when empty, its value is don't-care and benches shall not check it.
REQ-019 SHALL, for push only while not full, write the word, increment the write pointer and increment level, with new level visible 1 cycle later.
REQ-020 SHALL, for pop only while not empty, increment the read pointer and decrement level, with the next word on rd_data_o in the following cycle.
REQ-021 SHALL, for simultaneous push and pop while 0 < level < DEPTH, perform both and leave level unchanged.
REQ-022 SHALL, for simultaneous push and pop while full, perform both (pop frees the slot), leave level at DEPTH and not set ovf.
REQ-023 SHALL, for simultaneous push and pop while empty, accept the push, ignore the pop, move level from 0 to 1 and not set udf.
REQ-024 SHALL, for push while full without pop, drop the word, leave pointers and level unchanged and set ovf.
REQ-025 SHALL, for pop while empty without push, leave state unchanged and set udf.
REQ-026 SHALL set eot_pend on eot_i.
REQ-027 SHALL, when a sticky flag is set and cleared in the same cycle, give the set priority.
REQ-028 SHALL compute the threshold source as thr = (thresh_i != 0) && (level >= thresh_i), level-sensitive and not sticky, using registered level.
REQ-029 SHALL register irq_o as (thr & irq_en_i[0]) | (eot_pend & irq_en_i[1]) | (ovf & irq_en_i[2]), so it lags its sources by 1 cycle.
REQ-030 SHALL compute full_o = (level == DEPTH) and empty_o = (level == 0) combinationally from the registered level.

Reset
REQ-031 SHALL, on prstn_i low and asynchronously, clear pointers, level, sticky flags and irq_o to 0, giving empty_o = 1, full_o = 0, level_o = 0 and sts_o = 0.
REQ-032 SHALL leave RAM contents unreset.
REQ-033 SHALL deassert reset synchronously to pclk_i, handled externally.
REQ-034 SHALL, on reset mid-operation, discard all stored words, with the first post-reset push landing in entry 0.

Structure
REQ-035 SHALL place the irq/status bit indices (THR=0, EOT=1, OVF=2, UDF=0) in a shared package spi_pkg, alongside the SPI register offsets.
REQ-036 SHALL use one natural sub-module, spi_rx_irq, containing the sticky flags and irq register; the storage stays in the top.

Verification
REQ-037 SHALL verify fill and drain: push 0x11111111..0x44444444 with DEPTH=4 -> full_o=1 and level_o=4; then 4 pops -> rd_data_o reads 0x11111111..0x44444444 in order, then empty_o=1.
REQ-038 SHALL verify overflow: push 0xDEADBEEF while full with no pop -> level stays 4, sts_o[2]=1, the head is unchanged, and with irq_en_i=3'b100 irq_o=1 one cycle later; sts_clr_i=3'b100 -> sts_o[2]=0 and irq_o=0 one cycle later.
REQ-039 SHALL verify simultaneous events: push with pop when full -> level stays 4 and ovf=0; push with pop when empty -> level 1 and udf=0; pop when empty alone -> sts_o[0]=1.
REQ-040 SHALL verify the threshold: thresh_i=3 and irq_en_i=3'b001; push 3 words -> irq_o rises 1 cycle after level_o=3; pop 1 -> irq_o falls; thresh_i=0 -> irq_o never rises.
REQ-041 SHALL verify EOT with a same-cycle clear: eot_i together with sts_clr_i[1] -> eot_pend=1 (set wins).
REQ-042 SHALL verify wrap and reset: 10 push/pop pairs -> data order preserved across pointer wrap; assert prstn_i at level 2 -> level_o=0 immediately, and the next push/pop returns the new word.
